// File: rtl/drum_step_sequencer_if.sv
// Bus bundle for the drum step sequencer: run level, pattern-write
// port and the trigger outputs toward the per-voice playback counters.
interface drum_step_sequencer_if;
    logic       run;
    logic       pattern_wr;
    logic [1:0] pattern_voice;
    logic [3:0] pattern_step;
    logic       pattern_bit;
    logic       sample_en;
    logic [3:0] voice_go;
    logic       step_strobe;
    logic [3:0] step_idx;

    modport master (
        output run, pattern_wr, pattern_voice, pattern_step, pattern_bit,
        input  sample_en, voice_go, step_strobe, step_idx
    );

    modport slave (
        input  run, pattern_wr, pattern_voice, pattern_step, pattern_bit,
        output sample_en, voice_go, step_strobe, step_idx
    );
endinterface

// File: rtl/drum_step_sequencer.sv
// Drum step sequencer: sample-rate divider, 16-step x 4-voice pattern
// memory and tempo step timer producing one-cycle per-voice triggers.
// Voice order: bit0 kick, bit1 snare, bit2 hihat, bit3 cymbal.
// Optional feature macro: DRUM_SEQ_SWING_EN (even steps long, odd steps
// short by SWING_SAMPLES; pair length unchanged).
module drum_step_sequencer #(
    parameter int SAMPLE_DIV    = 1042,
    parameter int STEP_SAMPLES  = 6000,
    parameter int SWING_SAMPLES = 1000
) (
    input  logic                         i_clk,
    input  logic                         i_resetn,
    drum_step_sequencer_if.slave         seq_bus
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int CNT_W = $clog2(STEP_SAMPLES + SWING_SAMPLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef DRUM_SEQ_SWING_EN
    localparam logic [CNT_W-1:0] LEN_EVEN_LAST = CNT_W'(STEP_SAMPLES + SWING_SAMPLES - 1);
    localparam logic [CNT_W-1:0] LEN_ODD_LAST  = CNT_W'(STEP_SAMPLES - SWING_SAMPLES - 1);
`else
    localparam logic [CNT_W-1:0] LEN_LAST      = CNT_W'(STEP_SAMPLES - 1);
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic             r_sample_en;
    logic             w_sample_en_nxt;
    logic [CNT_W-1:0] r_samp_cnt;
    logic [CNT_W-1:0] w_samp_cnt_nxt;
    logic [3:0]       r_step_idx;
    logic [3:0]       w_step_idx_nxt;
    logic [3:0]       w_step_inc;
    logic [3:0]       r_voice_go;
    logic [3:0]       w_voice_go_nxt;
    logic             r_step_strobe;
    logic             w_step_strobe_nxt;
    logic [CNT_W-1:0] w_len_last;

    // Indexed [step][voice]; one 4-bit voice column word per step.
    logic [3:0]       r_pattern [16];

    assign w_step_inc = r_step_idx + 4'd1;

`ifdef DRUM_SEQ_SWING_EN
    // Length of the step being played depends on its parity.
    assign w_len_last = r_step_idx[0] ? LEN_ODD_LAST : LEN_EVEN_LAST;
`else
    assign w_len_last = LEN_LAST;
`endif

    // Pattern memory: cleared by reset, single-bit writes at any time.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            for (int i = 0; i < 16; i++) begin
                r_pattern[i] <= 4'b0000;
            end
        end else if (seq_bus.pattern_wr) begin
            r_pattern[seq_bus.pattern_step][seq_bus.pattern_voice] <= seq_bus.pattern_bit;
        end
    end

    // State register for the IDLE/RUN sequencer.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, divider, step timer and trigger decode.
    always_comb begin
        w_state_nxt       = r_state;
        w_div_nxt         = (r_div == DIV_LAST) ? '0 : (r_div + DIV_ONE);
        w_samp_cnt_nxt    = r_samp_cnt;
        w_step_idx_nxt    = r_step_idx;
        w_voice_go_nxt    = 4'b0000;
        w_step_strobe_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (seq_bus.run) begin
                    // Restart the divider so the first step is exactly len*SAMPLE_DIV clks.
                    w_state_nxt       = ST_RUN;
                    w_div_nxt         = '0;
                    w_samp_cnt_nxt    = '0;
                    w_step_idx_nxt    = 4'd0;
                    w_voice_go_nxt    = r_pattern[4'd0];
                    w_step_strobe_nxt = 1'b1;
                end else begin
                    w_samp_cnt_nxt    = '0;
                    w_step_idx_nxt    = 4'd0;
                end
            end
            ST_RUN: begin
                if (!seq_bus.run) begin
                    w_state_nxt       = ST_IDLE;
                    w_samp_cnt_nxt    = '0;
                    w_step_idx_nxt    = 4'd0;
                end else if (r_sample_en) begin
                    if (r_samp_cnt == w_len_last) begin
                        // Pattern read sees contents from before any same-edge write.
                        w_samp_cnt_nxt    = '0;
                        w_step_idx_nxt    = w_step_inc;
                        w_voice_go_nxt    = r_pattern[w_step_inc];
                        w_step_strobe_nxt = 1'b1;
                    end else begin
                        w_samp_cnt_nxt    = r_samp_cnt + CNT_ONE;
                    end
                end else begin
                    w_samp_cnt_nxt    = r_samp_cnt;
                end
            end
            default: begin
                w_state_nxt       = ST_IDLE;
                w_samp_cnt_nxt    = '0;
                w_step_idx_nxt    = 4'd0;
            end
        endcase

        w_sample_en_nxt = (w_div_nxt == DIV_LAST);
    end

    // Datapath registers; all outputs come straight from these.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_div         <= '0;
            r_sample_en   <= 1'b0;
            r_samp_cnt    <= '0;
            r_step_idx    <= 4'd0;
            r_voice_go    <= 4'b0000;
            r_step_strobe <= 1'b0;
        end else begin
            r_div         <= w_div_nxt;
            r_sample_en   <= w_sample_en_nxt;
            r_samp_cnt    <= w_samp_cnt_nxt;
            r_step_idx    <= w_step_idx_nxt;
            r_voice_go    <= w_voice_go_nxt;
            r_step_strobe <= w_step_strobe_nxt;
        end
    end

    assign seq_bus.sample_en   = r_sample_en;
    assign seq_bus.voice_go    = r_voice_go;
    assign seq_bus.step_strobe = r_step_strobe;
    assign seq_bus.step_idx    = r_step_idx;

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Self-checking bench for drum_step_sequencer: directed scenarios plus a
// randomized phase, all compared against a timeline model that derives
// expected outputs from elapsed clock counts.
module tb_drum_step_sequencer;

    localparam int SAMPLE_DIV    = 4;
    localparam int STEP_SAMPLES  = 3;
    localparam int SWING_SAMPLES = 1;

    logic clk;
    logic resetn;
    int   errors;
    int   checks;

    drum_step_sequencer_if seq_if ();

    drum_step_sequencer #(
        .SAMPLE_DIV    (SAMPLE_DIV),
        .STEP_SAMPLES  (STEP_SAMPLES),
        .SWING_SAMPLES (SWING_SAMPLES)
    ) dut (
        .i_clk    (clk),
        .i_resetn (resetn),
        .seq_bus  (seq_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    int         cyc;
    int         m_start;
    int         m_origin;
    bit         m_running;
    logic [3:0] m_pat [16];
    logic [3:0] m_old [16];
    logic [3:0] e_go;
    logic [3:0] e_idx;
    logic       e_strobe;
    logic       e_sen;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance the timeline model by one clock edge using the current inputs.
    task automatic model_edge();
        int e;
        int stp;
        bit bnd;
        cyc++;
        if (!resetn) begin
            for (int i = 0; i < 16; i++) m_pat[i] = 4'b0000;
            m_running = 1'b0;
            m_origin  = cyc;
            e_go      = 4'b0000;
            e_idx     = 4'd0;
            e_strobe  = 1'b0;
        end else begin
            m_old = m_pat;
            if (seq_if.pattern_wr)
                m_pat[seq_if.pattern_step][seq_if.pattern_voice] = seq_if.pattern_bit;
            e_go     = 4'b0000;
            e_strobe = 1'b0;
            if (!m_running) begin
                e_idx = 4'd0;
                if (seq_if.run) begin
                    m_running = 1'b1;
                    m_start   = cyc;
                    m_origin  = cyc;
                    e_go      = m_old[0];
                    e_strobe  = 1'b1;
                end
            end else if (!seq_if.run) begin
                m_running = 1'b0;
                e_idx     = 4'd0;
            end else begin
                e = cyc - m_start;
`ifdef DRUM_SEQ_SWING_EN
                begin
                    int pair_clks;
                    int long_clks;
                    int within;
                    pair_clks = 2 * STEP_SAMPLES * SAMPLE_DIV;
                    long_clks = (STEP_SAMPLES + SWING_SAMPLES) * SAMPLE_DIV;
                    within    = e % pair_clks;
                    stp       = (e / pair_clks) * 2 + ((within >= long_clks) ? 1 : 0);
                    bnd       = (within == 0) || (within == long_clks);
                end
`else
                stp = e / (STEP_SAMPLES * SAMPLE_DIV);
                bnd = (e % (STEP_SAMPLES * SAMPLE_DIV)) == 0;
`endif
                e_idx = 4'(stp % 16);
                if (bnd) begin
                    e_go     = m_old[e_idx];
                    e_strobe = 1'b1;
                end
            end
        end
        e_sen = ((cyc - m_origin) % SAMPLE_DIV) == (SAMPLE_DIV - 1);
    endtask

    // One clock: update the model on the edge, compare 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("sample_en",   32'(seq_if.sample_en),   32'(e_sen));
        check_eq("voice_go",    32'(seq_if.voice_go),    32'(e_go));
        check_eq("step_strobe", 32'(seq_if.step_strobe), 32'(e_strobe));
        check_eq("step_idx",    32'(seq_if.step_idx),    32'(e_idx));
    endtask

    task automatic write_bit(input logic [1:0] voice, input logic [3:0] step, input logic value);
        seq_if.pattern_wr    = 1'b1;
        seq_if.pattern_voice = voice;
        seq_if.pattern_step  = step;
        seq_if.pattern_bit   = value;
        tick();
        seq_if.pattern_wr    = 1'b0;
    endtask

    int strobes;
    int go_pulses;

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        m_start = 0;
        m_origin = 0;
        m_running = 1'b0;
        for (int i = 0; i < 16; i++) m_pat[i] = 4'b0000;
        resetn               = 1'b0;
        seq_if.run           = 1'b0;
        seq_if.pattern_wr    = 1'b0;
        seq_if.pattern_voice = 2'd0;
        seq_if.pattern_step  = 4'd0;
        seq_if.pattern_bit   = 1'b0;

        // 1. reset, then idle divider
        repeat (3) tick();
        resetn = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        // 2. program cymbal steps 0,4 and kick step 4, then start
        write_bit(2'd3, 4'd0, 1'b1);
        write_bit(2'd3, 4'd4, 1'b1);
        write_bit(2'd0, 4'd4, 1'b1);
        seq_if.run = 1'b1;
        tick();
        check_eq("start_go",     32'(seq_if.voice_go),    32'h8);
        check_eq("start_strobe", 32'(seq_if.step_strobe), 32'h1);
        check_eq("start_idx",    32'(seq_if.step_idx),    32'h0);

        // 3. one full loop: step 4 at +48, wrap at +192, 16 strobes
        strobes = 0;
        for (int i = 1; i <= 192; i++) begin
            tick();
            if (seq_if.step_strobe) strobes++;
            if (i == 48) begin
                check_eq("step4_idx", 32'(seq_if.step_idx), 32'h4);
                check_eq("step4_go",  32'(seq_if.voice_go), 32'h9);
            end
        end
        check_eq("wrap_idx",     32'(seq_if.step_idx), 32'h0);
        check_eq("wrap_go",      32'(seq_if.voice_go), 32'h8);
        check_eq("loop_strobes", 32'(strobes),         32'd16);

        // 4. stop mid step 2, idle a while, restart
        for (int i = 0; i < 30; i++) tick();
        seq_if.run = 1'b0;
        tick();
        check_eq("stop_idx",    32'(seq_if.step_idx),    32'h0);
        check_eq("stop_go",     32'(seq_if.voice_go),    32'h0);
        check_eq("stop_strobe", 32'(seq_if.step_strobe), 32'h0);
        for (int i = 0; i < 9; i++) tick();
        seq_if.run = 1'b1;
        tick();
        check_eq("restart_go",     32'(seq_if.voice_go),    32'h8);
        check_eq("restart_strobe", 32'(seq_if.step_strobe), 32'h1);

        // 5. write cymbal step4=0 on the edge that enters step 4
        for (int i = 0; i < 47; i++) tick();
        write_bit(2'd3, 4'd4, 1'b0);
        check_eq("same_edge_go", 32'(seq_if.voice_go), 32'h9);
        for (int i = 0; i < 192; i++) tick();
        check_eq("next_loop_go", 32'(seq_if.voice_go), 32'h1);

        // 6. reset mid-run clears the pattern
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        go_pulses = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (seq_if.voice_go != 4'b0000) go_pulses++;
        end
        check_eq("post_reset_go", 32'(go_pulses), 32'd0);

        // Randomized phase: writes, run toggles, occasional reset
        for (int n = 0; n < 4000; n++) begin
            seq_if.pattern_wr    = ($urandom_range(3) == 0);
            seq_if.pattern_voice = 2'($urandom_range(3));
            seq_if.pattern_step  = 4'($urandom_range(15));
            seq_if.pattern_bit   = ($urandom_range(2) != 0);
            if ($urandom_range(399) == 0) seq_if.run = ~seq_if.run;
            resetn = ($urandom_range(999) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
